// File: rtl/counter_pkg.sv
// Shared constants and helpers for the multi-digit score counter.
package counter_pkg;

    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned RADIX_BCD = 10;
    localparam int unsigned RADIX_HEX = 16;

    // Digit value at which a stage rolls over in the given direction.
    function automatic logic [DIGIT_W-1:0] terminal_value(input int unsigned radix,
                                                          input logic        up);
        return up ? DIGIT_W'(radix - 1) : '0;
    endfunction

endpackage

// File: rtl/count_digit.sv
// One counter stage: 4-bit digit register with clamped load, up/down step and terminal flag.
module count_digit
    import counter_pkg::*;
#(
    parameter int unsigned RADIX = 10
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               up,
    input  logic               load,
    input  logic               sclr,
    input  logic               step,
    input  logic [DIGIT_W-1:0] load_val,
    output logic [DIGIT_W-1:0] q,
    output logic               term
);

    localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);

    logic [DIGIT_W-1:0] digit_q, digit_d;

    assign q    = digit_q;
    assign term = (digit_q == terminal_value(RADIX, up));

    always_comb begin
        digit_d = digit_q;
        if (sclr) begin
            digit_d = '0;
        end else if (load) begin
            digit_d = (load_val > MAX) ? MAX : load_val;
        end else if (step) begin
            if (up) begin
                digit_d = (digit_q == MAX) ? '0 : digit_q + 1'b1;
            end else begin
                digit_d = (digit_q == '0) ? MAX : digit_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/score_counter.sv
// Multi-digit BCD/hex up/down counter with prescaler, ripple carries and terminal-count pulse.
module score_counter
    import counter_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned RADIX    = 10,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        clear,
    input  logic                        en,
    input  logic                        up,
    input  logic                        load,
    input  logic [DIGIT_W*DIGITS-1:0]   d,
    input  logic                        sclr,
    output logic [DIGIT_W*DIGITS-1:0]   q,
    output logic [DIGITS-1:0]           co,
    output logic                        tc
);

    if (RADIX != RADIX_BCD && RADIX != RADIX_HEX) begin : g_bad_radix
        $error("score_counter: RADIX must be 10 or 16");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("score_counter: DIGITS must be 1..8");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("score_counter: PRESCALE must be 1..65535");
    end

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
    localparam logic        SAT      = (SATURATE != 0);

    logic [15:0]       pre_q, pre_d;
    logic              tick;
    logic [DIGITS-1:0] term, low_term, step;
    logic              term_event, hold;
    logic              tc_q;

    // clear is folded in so co drops the moment clear rises, not at the next edge.
    assign tick = en & ~clear & ~sclr & ~load & (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (sclr || load || tick) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + 16'd1;
        end
    end

    always_comb begin
        logic acc;
        acc = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            low_term[i] = acc;
            acc         = acc & term[i];
        end
    end

    assign co         = {DIGITS{tick}} & low_term & term;
    assign term_event = co[DIGITS-1];
    assign hold       = term_event & SAT;
    assign step       = {DIGITS{tick & ~hold}} & low_term;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        count_digit #(
            .RADIX(RADIX)
        ) u_digit (
            .clk     (clk),
            .clear   (clear),
            .up      (up),
            .load    (load),
            .sclr    (sclr),
            .step    (step[g]),
            .load_val(d[DIGIT_W*g +: DIGIT_W]),
            .q       (q[DIGIT_W*g +: DIGIT_W]),
            .term    (term[g])
        );
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            pre_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            pre_q <= pre_d;
            tc_q  <= term_event;
        end
    end

    assign tc = tc_q;

endmodule
